brick_scan: RTL and testbench

// - Read-side counterpart of the level loader: walks brick RAM addresses 0..BRICK_NUM-1,

---
 rtl/brick_scan_pkg.sv | 49 ++++
 rtl/brick_scan_if.sv | 30 +++
 rtl/brick_addr_to_xy.sv | 29 ++
 rtl/brick_scan.sv | 126 ++++++++++++
 tb/tb_brick_scan.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/brick_scan_pkg.sv
// brick_scan_pkg: definitions shared by the brick scan FSM, its draw interface
// and the address-to-screen converter (the level loader uses the same geometry).
//   - BRICKNUM, COLS_LOG2_DEF, BRICK_W_DEF, BRICK_H_DEF : default field geometry
//   - HEALTH_* : 2-bit brick health encoding held in brick RAM
//   - COLOUR_* : 3-bit colour codes sent to the VGA draw engine
//   - state_t  : scan FSM states (also exported on the debug port)
//   - health_colour() : health -> colour mapping
package brick_scan_pkg;

  localparam int ADDR_W   = 10;
  localparam int COORD_W  = 10;
  localparam int COLOUR_W = 3;

  localparam int                 BRICKNUM      = 64;
  localparam int                 COLS_LOG2_DEF = 4;
  localparam logic [COORD_W-1:0] BRICK_W_DEF   = 10'd20;
  localparam logic [COORD_W-1:0] BRICK_H_DEF   = 10'd8;

  localparam logic [1:0] HEALTH_DEAD = 2'd0;
  localparam logic [1:0] HEALTH_LOW  = 2'd1;
  localparam logic [1:0] HEALTH_MID  = 2'd2;
  localparam logic [1:0] HEALTH_FULL = 2'd3;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK  = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_GREEN  = 3'b010;
  localparam logic [COLOUR_W-1:0] COLOUR_YELLOW = 3'b110;
  localparam logic [COLOUR_W-1:0] COLOUR_RED    = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_DRAW = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  function automatic logic [COLOUR_W-1:0] health_colour(input logic [1:0] health);
    logic [COLOUR_W-1:0] c;
    case (health)
      HEALTH_FULL: c = COLOUR_RED;
      HEALTH_MID:  c = COLOUR_YELLOW;
      HEALTH_LOW:  c = COLOUR_GREEN;
      default:     c = COLOUR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/brick_scan_if.sv
// brick_scan_if: brick draw request channel between the scanner and the VGA
// draw engine.
//   - draw_req : scanner asks for one brick to be drawn
//   - draw_ack : draw engine has finished the current brick
//   - x_out, y_out : brick top-left pixel position
//   - colour   : brick colour
// Handshake: draw_req rises with x_out/y_out/colour already valid and holds
// them constant until a cycle in which draw_ack=1 is sampled at a rising clk
// edge; that edge completes the transfer. An ack in the very first draw_req
// cycle is accepted. draw_ack while draw_req=0 has no meaning and is ignored.
interface brick_scan_if;
  import brick_scan_pkg::*;

  logic                draw_req;
  logic                draw_ack;
  logic [COORD_W-1:0]  x_out;
  logic [COORD_W-1:0]  y_out;
  logic [COLOUR_W-1:0] colour;

  modport master (
    output draw_req, x_out, y_out, colour,
    input  draw_ack
  );

  modport slave (
    input  draw_req, x_out, y_out, colour,
    output draw_ack
  );

endinterface

// File: rtl/brick_addr_to_xy.sv
// brick_addr_to_xy: combinational brick RAM address -> screen top-left pixel.
//   - addr : brick address; column = low COLS_LOG2 bits, row = remaining bits
//   - x    : column * BRICK_W, truncated to 10 bits
//   - y    : row * BRICK_H, truncated to 10 bits
module brick_addr_to_xy
  import brick_scan_pkg::*;
#(
  parameter int                 COLS_LOG2 = COLS_LOG2_DEF,
  parameter logic [COORD_W-1:0] BRICK_W   = BRICK_W_DEF,
  parameter logic [COORD_W-1:0] BRICK_H   = BRICK_H_DEF
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam logic [ADDR_W-1:0] COL_MASK = ADDR_W'((1 << COLS_LOG2) - 1);

  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row;

  assign col = addr & COL_MASK;
  assign row = addr >> COLS_LOG2;

  // Products evaluated in 10-bit context: off-screen positions wrap, no clamp.
  assign x = col * BRICK_W;
  assign y = row * BRICK_H;

endmodule

// File: rtl/brick_scan.sv
// brick_scan: walks brick RAM addresses 0..BRICK_NUM-1, reads each brick's
// health, requests one draw per live brick (or per brick when DRAW_DEAD=1,
// dead ones in black) and tallies surviving bricks for level-clear detection.
//   - clk, resetn   : clock, synchronous active-low reset
//   - start         : begin a scan (only looked at while idle)
//   - rd_address    : brick RAM read address (data returns one clk later)
//   - rd_health     : brick RAM read data
//   - draw          : draw request channel (master side)
//   - busy, done    : scan in progress / 1-clk end-of-scan pulse
//   - live_count    : live bricks found by the last completed scan
//   - level_clear   : last completed scan found no live bricks
//   - state_dbg     : current FSM state
module brick_scan
  import brick_scan_pkg::*;
#(
  parameter int                 BRICK_NUM = BRICKNUM,
  parameter int                 COLS_LOG2 = COLS_LOG2_DEF,
  parameter logic [COORD_W-1:0] BRICK_W   = BRICK_W_DEF,
  parameter logic [COORD_W-1:0] BRICK_H   = BRICK_H_DEF,
  parameter int                 DRAW_DEAD = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [1:0]        rd_health,
  brick_scan_if.master      draw,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] live_count,
  output logic              level_clear,
  output state_t            state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRICK_NUM - 1);
  localparam bit                DRAW_ALL  = (DRAW_DEAD != 0);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic [ADDR_W-1:0]    tally_q;
  logic [1:0]           health_q;
  logic [COORD_W-1:0]   x_q, y_q;
  logic [COLOUR_W-1:0]  colour_q;
  logic [ADDR_W-1:0]    live_q;
  logic                 clear_q;
  logic [COORD_W-1:0]   xy_x, xy_y;
  logic                 rd_live;

  brick_addr_to_xy #(
    .COLS_LOG2 (COLS_LOG2),
    .BRICK_W   (BRICK_W),
    .BRICK_H   (BRICK_H)
  ) u_xy (
    .addr (addr_q),
    .x    (xy_x),
    .y    (xy_y)
  );

  assign rd_live = (rd_health != HEALTH_DEAD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_READ;
      S_READ: state_d = S_WAIT;
      S_WAIT: state_d = (rd_live || DRAW_ALL) ? S_DRAW : S_NEXT;
      S_DRAW: if (draw.draw_ack) state_d = S_NEXT;
      S_NEXT: state_d = (addr_q == LAST_ADDR) ? S_DONE : S_READ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_addr_q <= '0;
      tally_q   <= '0;
      health_q  <= HEALTH_DEAD;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= COLOUR_BLACK;
      live_q    <= '0;
      clear_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_READ: rd_addr_q <= addr_q;
        S_WAIT: begin
          // Geometry is captured here so it stays frozen for the whole draw.
          health_q <= rd_health;
          x_q      <= xy_x;
          y_q      <= xy_y;
          colour_q <= health_colour(rd_health);
        end
        S_NEXT: begin
          tally_q <= tally_q + {{(ADDR_W-1){1'b0}}, (health_q != HEALTH_DEAD)};
          if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
        end
        S_DONE: begin
          live_q  <= tally_q;
          clear_q <= (tally_q == '0);
          tally_q <= '0;
          addr_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Address is presented combinationally in S_READ so data lands in S_WAIT;
  // otherwise the last presented address is held.
  assign rd_address    = (state_q == S_READ) ? addr_q : rd_addr_q;
  assign draw.draw_req = (state_q == S_DRAW);
  assign draw.x_out    = x_q;
  assign draw.y_out    = y_q;
  assign draw.colour   = colour_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign live_count    = live_q;
  assign level_clear   = clear_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_brick_scan.sv
// tb_brick_scan: three brick_scan instances (4 bricks, 4 bricks with dead
// bricks drawn, 20 bricks) each with its own RAM model, driven one at a time
// and checked against a geometric/health model of the scan.
module tb_brick_scan;
  import brick_scan_pkg::*;

  localparam int NDUT = 3;
  localparam int BN [NDUT] = '{4, 4, 20};
  localparam int DD [NDUT] = '{0, 1, 0};
  localparam int COLS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic       start   [NDUT];
  logic       ack     [NDUT];
  logic [1:0] ram     [NDUT][1024];
  logic       o_busy  [NDUT];
  logic       o_done  [NDUT];
  logic       o_req   [NDUT];
  logic       o_clear [NDUT];
  logic [9:0] o_addr  [NDUT];
  logic [9:0] o_x     [NDUT];
  logic [9:0] o_y     [NDUT];
  logic [9:0] o_live  [NDUT];
  logic [2:0] o_col   [NDUT];
  int         last_live [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    brick_scan_if drw();
    logic [9:0] rd_address;
    logic [1:0] rd_health;
    logic       busy, done, level_clear;
    logic [9:0] live_count;
    state_t     state_dbg;

    assign drw.draw_ack = ack[g];
    always @(posedge clk) rd_health <= ram[g][rd_address];

    brick_scan #(
      .BRICK_NUM (BN[g]),
      .COLS_LOG2 (COLS),
      .BRICK_W   (10'd20),
      .BRICK_H   (10'd8),
      .DRAW_DEAD (DD[g])
    ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start[g]),
      .rd_address  (rd_address),
      .rd_health   (rd_health),
      .draw        (drw),
      .busy        (busy),
      .done        (done),
      .live_count  (live_count),
      .level_clear (level_clear),
      .state_dbg   (state_dbg)
    );

    assign o_busy[g]  = busy;
    assign o_done[g]  = done;
    assign o_req[g]   = drw.draw_req;
    assign o_clear[g] = level_clear;
    assign o_addr[g]  = rd_address;
    assign o_x[g]     = drw.x_out;
    assign o_y[g]     = drw.y_out;
    assign o_col[g]   = drw.colour;
    assign o_live[g]  = live_count;
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [9:0] model_x(input int a);
    return 10'((a % (1 << COLS)) * 20);
  endfunction

  function automatic logic [9:0] model_y(input int a);
    return 10'((a / (1 << COLS)) * 8);
  endfunction

  function automatic logic [2:0] model_colour(input logic [1:0] h);
    case (h)
      2'd3:    return 3'b100;
      2'd2:    return 3'b110;
      2'd1:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_random(input int g);
    for (int a = 0; a < BN[g]; a++) ram[g][a] = 2'($urandom_range(0, 3));
    if (BN[g] > 17) begin
      ram[g][15] = 2'd3;
      ram[g][17] = 2'd1;
    end
  endtask

  task automatic fill_const(input int g, input logic [1:0] h);
    for (int a = 0; a < BN[g]; a++) ram[g][a] = h;
  endtask

  // One full scan: drives start/ack (with optional stray start/ack noise),
  // checks every draw against the model queue and the end-of-scan results.
  task automatic run_scan(input int g, input int smin, input int smax, input bit noise);
    logic [32:0] exp_q[$];
    logic [32:0] e;
    int base, exp_live, stall_total, cycles, wait_left;
    bit in_draw;
    logic [9:0] hx, hy;
    logic [2:0] hc;
    base = 0; exp_live = 0; stall_total = 0; wait_left = 0; in_draw = 0;
    hx = '0; hy = '0; hc = '0;
    for (int a = 0; a < BN[g]; a++) begin
      if (ram[g][a] != 2'd0) exp_live++;
      if (ram[g][a] != 2'd0 || DD[g] != 0) begin
        exp_q.push_back({10'(a), model_x(a), model_y(a), model_colour(ram[g][a])});
        base += 4;
      end else begin
        base += 3;
      end
    end
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
    check("busy_start", o_busy[g], 1);
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (o_done[g]) break;
      if (cycles > 4000) begin
        check("scan_timeout", 1, 0);
        break;
      end
      check("busy", o_busy[g], 1);
      check("live_stable", o_live[g], 32'(last_live[g]));
      start[g] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (o_req[g]) begin
        if (!in_draw) begin
          in_draw = 1;
          if (exp_q.size() == 0) begin
            check("extra_draw", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("draw_addr", o_addr[g], e[32:23]);
            check("draw_x", o_x[g], e[22:13]);
            check("draw_y", o_y[g], e[12:3]);
            check("draw_colour", o_col[g], e[2:0]);
            if (g == 2 && e[32:23] == 10'd17) begin
              check("geom17_x", o_x[g], 20);
              check("geom17_y", o_y[g], 8);
            end
            if (g == 2 && e[32:23] == 10'd15) begin
              check("geom15_x", o_x[g], 300);
              check("geom15_y", o_y[g], 0);
            end
          end
          hx = o_x[g]; hy = o_y[g]; hc = o_col[g];
          wait_left = $urandom_range(smax, smin);
          stall_total += wait_left;
        end else begin
          check("hold_x", o_x[g], hx);
          check("hold_y", o_y[g], hy);
          check("hold_colour", o_col[g], hc);
        end
        if (wait_left == 0) ack[g] = 1'b1;
        else begin
          ack[g] = 1'b0;
          wait_left--;
        end
      end else begin
        in_draw = 0;
        ack[g] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    ack[g] = 1'b0;
    start[g] = 1'b0;
    check("done_cycles", cycles, 32'(base + stall_total));
    check("draws_left", exp_q.size(), 0);
    @(negedge clk);
    check("done_pulse", o_done[g], 0);
    check("busy_end", o_busy[g], 0);
    check("live_count", o_live[g], 32'(exp_live));
    check("level_clear", o_clear[g], (exp_live == 0) ? 1 : 0);
    last_live[g] = exp_live;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    resetn = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      start[g] = 1'b1;
      ack[g] = 1'b0;
      last_live[g] = 0;
      for (int a = 0; a < 1024; a++) ram[g][a] = 2'd0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("rst_busy", o_busy[g], 0);
      check("rst_done", o_done[g], 0);
      check("rst_req", o_req[g], 0);
      check("rst_x", o_x[g], 0);
      check("rst_y", o_y[g], 0);
      check("rst_colour", o_col[g], 0);
      check("rst_live", o_live[g], 0);
      check("rst_clear", o_clear[g], 0);
      check("rst_addr", o_addr[g], 0);
    end
    resetn = 1'b1;
    for (int g = 0; g < NDUT; g++) start[g] = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check("start_in_reset_ignored", o_busy[g], 0);

    // Reference field {3,1,0,2}, immediate ack.
    ram[0][0] = 2'd3; ram[0][1] = 2'd1; ram[0][2] = 2'd0; ram[0][3] = 2'd2;
    run_scan(0, 0, 0, 0);
    // Cleared field, dead bricks skipped.
    fill_const(0, 2'd0);
    run_scan(0, 0, 0, 0);
    // Cleared field, dead bricks drawn black.
    fill_const(1, 2'd0);
    run_scan(1, 0, 0, 0);
    // Reference field with stalls and stray start/ack.
    ram[1][0] = 2'd3; ram[1][1] = 2'd1; ram[1][2] = 2'd0; ram[1][3] = 2'd2;
    run_scan(1, 0, 10, 1);
    // Larger field: fixed 10-clk ack stall, then random rounds.
    fill_random(2);
    run_scan(2, 10, 10, 1);
    for (int r = 0; r < 3; r++) begin
      fill_random(2);
      run_scan(2, 0, 3, 1);
    end

    // Reset in the middle of drawing brick 2.
    fill_const(2, 2'd3);
    ack[2] = 1'b1;
    @(negedge clk); start[2] = 1'b1;
    @(negedge clk); start[2] = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_req", o_req[2], 1);
    check("mid_addr", o_addr[2], 2);
    check("mid_x", o_x[2], 32'(model_x(2)));
    ack[2] = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", o_busy[2], 0);
    check("mid_rst_req", o_req[2], 0);
    check("mid_rst_live", o_live[2], 0);
    check("mid_rst_clear", o_clear[2], 0);
    resetn = 1'b1;
    for (int g = 0; g < NDUT; g++) last_live[g] = 0;
    fill_random(2);
    run_scan(2, 0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
